// File: rtl/instr_fetch_pkg.sv
// Shared widths, FIFO geometry and FSM encoding for the instruction fetch unit.
package fetch_pkg;

    localparam int unsigned ADDR_W     = 8;
    localparam int unsigned INSTR_W    = 16;
    localparam int unsigned FIFO_DEPTH = 2;
    localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef logic [ADDR_W-1:0]  addr_t;
    typedef logic [INSTR_W-1:0] instr_t;
    typedef logic [CNT_W-1:0]   cnt_t;

    // IDLE: free to issue; WAIT: one read in flight; DROP: in-flight read is stale
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_e;

    typedef struct packed {
        addr_t  addr;
        instr_t instr;
    } fifo_entry_t;

    // Address increment with silent 8-bit wrap.
    function automatic addr_t addr_inc(input addr_t a);
        return a + addr_t'(1);
    endfunction

endpackage

// File: rtl/instr_fetch_fifo.sv
// Prefetch buffer holding {addr, instr} pairs; supports simultaneous push and pop,
// and a flush that empties it in one cycle.
module prefetch_fifo
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        push,
    input  fifo_entry_t push_entry,
    input  logic        pop,
    output fifo_entry_t head,
    output cnt_t        count,
    output logic        empty
);

    fifo_entry_t         mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    rd_ptr;
    logic [PTR_W-1:0]    wr_ptr;
    logic                full;
    logic                do_push;
    logic                do_pop;

    assign empty = (count == '0);
    assign full  = (count == cnt_t'(FIFO_DEPTH));

    // A pop frees the head slot in the same cycle, so a push into a full FIFO is
    // legal when it coincides with a pop.
    always_comb begin
        do_pop  = pop & ~empty;
        do_push = push & (~full | do_pop);
    end

    // Pointer and occupancy bookkeeping; flush discards everything buffered.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + cnt_t'(do_push) - cnt_t'(do_pop);
        end
    end

    // Storage array; contents are meaningless while count says empty, so no reset.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: prefetches up to two instructions ahead of the control
// unit, delivers them to IR on request, and handles redirects that may land
// while a memory read is still in flight.
module instr_fetch
    import fetch_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               fetch_req,
    input  logic               pc_ld,
    input  logic [ADDR_W-1:0]  pc_in,
    input  logic               halt,
    output logic               im_rd,
    output logic [ADDR_W-1:0]  im_addr,
    input  logic [INSTR_W-1:0] im_data,
    input  logic               im_valid,
    output logic [INSTR_W-1:0] ir_data,
    output logic               ir_wr,
    output logic [ADDR_W-1:0]  pc_out
);

    fetch_state_e state;
    fetch_state_e state_nx;

    addr_t        fpc;
    fifo_entry_t  head;
    fifo_entry_t  push_entry;
    cnt_t         count;
    logic         empty;

    logic         outstanding;
    logic [CNT_W:0] occupancy;
    logic         rsp_ok;
    logic         issue;
    logic         push;
    logic         pop;
    logic         flush;

    // A response can never arrive in the same cycle as its own read strobe, so a
    // valid seen then is left over from an abandoned read and is ignored.
    assign rsp_ok      = im_valid & ~im_rd;
    assign outstanding = (state != IDLE);
    assign occupancy   = {1'b0, count} + (CNT_W+1)'(outstanding);

    assign push_entry.addr  = im_addr;
    assign push_entry.instr = im_data;

    prefetch_fifo u_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .count      (count),
        .empty      (empty)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // FSM next state; a redirect with the response in the same cycle has nothing
    // left to drop, so it returns straight to IDLE.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (issue) begin
                    state_nx = WAIT;
                end
            end
            WAIT: begin
                if (rsp_ok) begin
                    state_nx = IDLE;
                end else if (pc_ld) begin
                    state_nx = DROP;
                end
            end
            DROP: begin
                if (rsp_ok) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // FSM outputs: read issue, FIFO push/pop/flush; a redirect overrides all of them.
    always_comb begin
        issue = 1'b0;
        push  = 1'b0;
        pop   = 1'b0;
        flush = pc_ld;
        if (state == IDLE && !halt && !pc_ld &&
            occupancy < (CNT_W+1)'(FIFO_DEPTH)) begin
            issue = 1'b1;
        end
        if (state == WAIT && rsp_ok && !pc_ld) begin
            push = 1'b1;
        end
        if (fetch_req && !empty && !pc_ld) begin
            pop = 1'b1;
        end
    end

    // Registered memory/IR/PC outputs and the fetch pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            fpc     <= '0;
            pc_out  <= '0;
            im_rd   <= 1'b0;
            im_addr <= '0;
            ir_wr   <= 1'b0;
            ir_data <= '0;
        end else begin
            im_rd <= issue;
            ir_wr <= pop;
            if (issue) begin
                im_addr <= fpc;
                fpc     <= addr_inc(fpc);
            end
            if (pop) begin
                ir_data <= head.instr;
                pc_out  <= addr_inc(head.addr);
            end
            if (pc_ld) begin
                fpc    <= pc_in;
                pc_out <= pc_in;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a vector table for the steady-state streams plus
// hand-written sequences for redirect, halt and reset corner cases.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        fetch_req = 1'b0;
    logic        pc_ld = 1'b0;
    logic [7:0]  pc_in = 8'h00;
    logic        halt = 1'b0;
    logic        im_rd;
    logic [7:0]  im_addr;
    logic [15:0] im_data;
    logic        im_valid;
    logic [15:0] ir_data;
    logic        ir_wr;
    logic [7:0]  pc_out;

    logic        mem_valid = 1'b0;
    logic [15:0] mem_data = 16'h0000;
    logic        xvalid = 1'b0;

    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        logic       rst, fr, ld;
        logic [7:0] pcin;
        logic       halt;
        logic       rd;
        logic [7:0] addr;
        logic       wr;
        logic [15:0] data;
        logic [7:0] pc;
    } vec_t;

    vec_t tbl[$];

    instr_fetch dut (
        .clk       (clk),
        .rst       (rst),
        .fetch_req (fetch_req),
        .pc_ld     (pc_ld),
        .pc_in     (pc_in),
        .halt      (halt),
        .im_rd     (im_rd),
        .im_addr   (im_addr),
        .im_data   (im_data),
        .im_valid  (im_valid),
        .ir_data   (ir_data),
        .ir_wr     (ir_wr),
        .pc_out    (pc_out)
    );

    always #5 clk = ~clk;

    // Memory contents: high byte scrambled from the address, low byte the address.
    function automatic logic [15:0] memf(input logic [7:0] a);
        return {a ^ 8'hC3, a};
    endfunction

    // Memory with fixed 1-cycle latency; xvalid injects a stray response.
    always @(posedge clk) begin
        mem_valid <= im_rd;
        mem_data  <= memf(im_addr);
    end

    assign im_valid = mem_valid | xvalid;
    assign im_data  = xvalid ? 16'hDEAD : mem_data;

    function automatic vec_t mk(input logic r, input logic f, input logic l,
                                input logic [7:0] p, input logic h,
                                input logic rd, input logic [7:0] ad,
                                input logic wr, input logic [15:0] d,
                                input logic [7:0] pc);
        vec_t v;
        v.rst = r; v.fr = f; v.ld = l; v.pcin = p; v.halt = h;
        v.rd = rd; v.addr = ad; v.wr = wr; v.data = d; v.pc = pc;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic f, input logic l,
                        input logic [7:0] p, input logic h, input logic x);
        rst = r; fetch_req = f; pc_ld = l; pc_in = p; halt = h; xvalid = x;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic rd, input logic [7:0] ad,
                           input logic wr, input logic [15:0] d, input logic [7:0] pc);
        chk({tag, "_im_rd"},   {15'd0, im_rd},   {15'd0, rd});
        chk({tag, "_im_addr"}, {8'd0, im_addr},  {8'd0, ad});
        chk({tag, "_ir_wr"},   {15'd0, ir_wr},   {15'd0, wr});
        chk({tag, "_ir_data"}, ir_data,          d);
        chk({tag, "_pc_out"},  {8'd0, pc_out},   {8'd0, pc});
    endtask

    initial begin
        // Stream with fetch_req held: one delivery every 3 cycles.
        tbl.push_back(mk(1,0,0,8'h00,0, 0,8'h00,0,16'h0000,8'h00));
        tbl.push_back(mk(0,1,0,8'h00,0, 1,8'h00,0,16'h0000,8'h00));
        tbl.push_back(mk(0,1,0,8'h00,0, 0,8'h00,0,16'h0000,8'h00));
        tbl.push_back(mk(0,1,0,8'h00,0, 0,8'h00,0,16'h0000,8'h00));
        tbl.push_back(mk(0,1,0,8'h00,0, 1,8'h01,1,memf(8'h00),8'h01));
        tbl.push_back(mk(0,1,0,8'h00,0, 0,8'h01,0,memf(8'h00),8'h01));
        tbl.push_back(mk(0,1,0,8'h00,0, 0,8'h01,0,memf(8'h00),8'h01));
        tbl.push_back(mk(0,1,0,8'h00,0, 1,8'h02,1,memf(8'h01),8'h02));
        tbl.push_back(mk(0,1,0,8'h00,0, 0,8'h02,0,memf(8'h01),8'h02));
        tbl.push_back(mk(0,1,0,8'h00,0, 0,8'h02,0,memf(8'h01),8'h02));
        tbl.push_back(mk(0,1,0,8'h00,0, 1,8'h03,1,memf(8'h02),8'h03));
        // No requests for 10 cycles: two reads, then FIFO full and quiet.
        tbl.push_back(mk(1,0,0,8'h00,0, 0,8'h00,0,16'h0000,8'h00));
        tbl.push_back(mk(0,0,0,8'h00,0, 1,8'h00,0,16'h0000,8'h00));
        tbl.push_back(mk(0,0,0,8'h00,0, 0,8'h00,0,16'h0000,8'h00));
        tbl.push_back(mk(0,0,0,8'h00,0, 0,8'h00,0,16'h0000,8'h00));
        tbl.push_back(mk(0,0,0,8'h00,0, 1,8'h01,0,16'h0000,8'h00));
        tbl.push_back(mk(0,0,0,8'h00,0, 0,8'h01,0,16'h0000,8'h00));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(0,0,0,8'h00,0, 0,8'h01,0,16'h0000,8'h00));
        // Drain the full FIFO back to back; refill starts when one slot frees.
        tbl.push_back(mk(0,1,0,8'h00,0, 0,8'h01,1,memf(8'h00),8'h01));
        tbl.push_back(mk(0,1,0,8'h00,0, 1,8'h02,1,memf(8'h01),8'h02));
        tbl.push_back(mk(0,0,0,8'h00,0, 0,8'h02,0,memf(8'h01),8'h02));
        // Redirect to FE and stream across the address wrap.
        tbl.push_back(mk(1,0,0,8'h00,0, 0,8'h00,0,16'h0000,8'h00));
        tbl.push_back(mk(0,0,1,8'hFE,0, 0,8'h00,0,16'h0000,8'hFE));
        tbl.push_back(mk(0,1,0,8'h00,0, 1,8'hFE,0,16'h0000,8'hFE));
        tbl.push_back(mk(0,1,0,8'h00,0, 0,8'hFE,0,16'h0000,8'hFE));
        tbl.push_back(mk(0,1,0,8'h00,0, 0,8'hFE,0,16'h0000,8'hFE));
        tbl.push_back(mk(0,1,0,8'h00,0, 1,8'hFF,1,memf(8'hFE),8'hFF));
        tbl.push_back(mk(0,1,0,8'h00,0, 0,8'hFF,0,memf(8'hFE),8'hFF));
        tbl.push_back(mk(0,1,0,8'h00,0, 0,8'hFF,0,memf(8'hFE),8'hFF));
        tbl.push_back(mk(0,1,0,8'h00,0, 1,8'h00,1,memf(8'hFF),8'h00));
        tbl.push_back(mk(0,1,0,8'h00,0, 0,8'h00,0,memf(8'hFF),8'h00));
        tbl.push_back(mk(0,1,0,8'h00,0, 0,8'h00,0,memf(8'hFF),8'h00));
        tbl.push_back(mk(0,1,0,8'h00,0, 1,8'h01,1,memf(8'h00),8'h01));
        tbl.push_back(mk(0,1,0,8'h00,0, 0,8'h01,0,memf(8'h00),8'h01));
        tbl.push_back(mk(0,1,0,8'h00,0, 0,8'h01,0,memf(8'h00),8'h01));
        tbl.push_back(mk(0,1,0,8'h00,0, 1,8'h02,1,memf(8'h01),8'h02));

        @(negedge clk);
        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].fr, tbl[i].ld, tbl[i].pcin, tbl[i].halt, 1'b0);
            chk_all($sformatf("tbl%0d", i), tbl[i].rd, tbl[i].addr, tbl[i].wr,
                    tbl[i].data, tbl[i].pc);
        end

        // Redirect while the read of 02 is in flight: its response is dropped.
        step(1,0,0,8'h00,0,0);
        repeat (7) step(0,1,0,8'h00,0,0);
        chk("drop_pre_rd", {15'd0, im_rd}, 16'd1);
        chk("drop_pre_addr", {8'd0, im_addr}, 16'h0002);
        step(0,1,1,8'h40,0,0);
        chk("drop_ld_wr", {15'd0, ir_wr}, 16'd0);
        chk("drop_ld_pc", {8'd0, pc_out}, 16'h0040);
        step(0,1,0,8'h00,0,0);
        chk("drop_rsp_wr", {15'd0, ir_wr}, 16'd0);
        chk("drop_rsp_rd", {15'd0, im_rd}, 16'd0);
        step(0,1,0,8'h00,0,0);
        chk("drop_new_rd", {15'd0, im_rd}, 16'd1);
        chk("drop_new_addr", {8'd0, im_addr}, 16'h0040);
        repeat (3) step(0,1,0,8'h00,0,0);
        chk("drop_first_wr", {15'd0, ir_wr}, 16'd1);
        chk("drop_first_data", ir_data, memf(8'h40));
        chk("drop_first_pc", {8'd0, pc_out}, 16'h0041);

        // Redirect, fetch_req and im_valid all in the same cycle, one entry buffered.
        step(1,0,0,8'h00,0,0);
        repeat (5) step(0,0,0,8'h00,0,0);
        step(0,1,1,8'h80,0,0);
        chk("same_wr", {15'd0, ir_wr}, 16'd0);
        chk("same_pc", {8'd0, pc_out}, 16'h0080);
        step(0,1,0,8'h00,0,0);
        chk("same_empty_wr", {15'd0, ir_wr}, 16'd0);
        chk("same_rd", {15'd0, im_rd}, 16'd1);
        chk("same_addr", {8'd0, im_addr}, 16'h0080);
        repeat (3) step(0,1,0,8'h00,0,0);
        chk("same_first_wr", {15'd0, ir_wr}, 16'd1);
        chk("same_first_data", ir_data, memf(8'h80));
        chk("same_first_pc", {8'd0, pc_out}, 16'h0081);

        // Halt with two buffered entries: both deliver, nothing new is read.
        step(1,0,0,8'h00,0,0);
        repeat (6) step(0,0,0,8'h00,0,0);
        step(0,1,0,8'h00,1,0);
        chk_all("halt_d0", 1'b0, 8'h01, 1'b1, memf(8'h00), 8'h01);
        step(0,1,0,8'h00,1,0);
        chk_all("halt_d1", 1'b0, 8'h01, 1'b1, memf(8'h01), 8'h02);
        repeat (2) begin
            step(0,1,0,8'h00,1,0);
            chk_all("halt_idle", 1'b0, 8'h01, 1'b0, memf(8'h01), 8'h02);
        end

        // Halt raised while a read is outstanding: that read still completes.
        step(1,0,0,8'h00,0,0);
        step(0,0,0,8'h00,0,0);
        step(0,0,0,8'h00,1,0);
        step(0,0,0,8'h00,1,0);
        step(0,1,0,8'h00,1,0);
        chk_all("halt_out", 1'b0, 8'h00, 1'b1, memf(8'h00), 8'h01);
        step(0,1,0,8'h00,1,0);
        chk_all("halt_out_idle", 1'b0, 8'h00, 1'b0, memf(8'h00), 8'h01);

        // Reset with a read in flight; the late response and a stray one are ignored.
        step(1,0,0,8'h00,0,0);
        repeat (7) step(0,1,0,8'h00,0,0);
        step(1,1,0,8'h00,0,0);
        chk_all("rst_mid", 1'b0, 8'h00, 1'b0, 16'h0000, 8'h00);
        step(0,1,0,8'h00,0,0);
        chk_all("rst_late", 1'b1, 8'h00, 1'b0, 16'h0000, 8'h00);
        step(0,1,0,8'h00,0,1);
        chk("rst_stray_wr", {15'd0, ir_wr}, 16'd0);
        step(0,1,0,8'h00,0,0);
        chk("rst_push_wr", {15'd0, ir_wr}, 16'd0);
        step(0,1,0,8'h00,0,0);
        chk_all("rst_first", 1'b1, 8'h01, 1'b1, memf(8'h00), 8'h01);

        step(0,0,0,8'h00,0,0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 clk  input  1  single clock; all state changes on the rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 fetch_req  input  1  control unit requests the next instruction into IR.
REQ-004 pc_ld  input  1  redirect strobe (branch/jump).
REQ-005 pc_in  input  8  redirect target address.
REQ-006 halt  input  1  suppresses new memory reads.
REQ-007 im_rd  output  1  one-cycle instruction-memory read strobe.
REQ-008 im_addr  output  8  read address; valid while im_rd=1.
REQ-009 im_data  input  16  memory read data; valid while im_valid=1.
REQ-010 im_valid  input  1  read response; arrives 1 or more cycles after im_rd, one response per read.
REQ-011 ir_data  output  16  instruction word driven onto the IR write bus.
REQ-012 ir_wr  output  1  IR write enable, one-cycle pulse.
REQ-013 pc_out  output  8  address of the next instruction to be delivered to IR.

Function
REQ-014 The block SHALL keep a 2-entry prefetch FIFO of {addr, instr} and a fetch pointer fpc.
- FIFO entries are pushed on im_valid in IDLE/WAIT handling.
REQ-015 The FSM SHALL have states IDLE, WAIT and DROP.
- IDLE -> WAIT: issue im_rd with im_addr=fpc when halt=0, pc_ld=0 and (count + outstanding) < 2; fpc <= fpc+1.
- WAIT -> IDLE: on im_valid, push im_data.
- WAIT -> DROP: on pc_ld.
- DROP -> IDLE: on im_valid; the data is discarded.
REQ-016 At most one read SHALL be outstanding; im_rd SHALL never assert in WAIT or DROP.
REQ-017 Delivery: when fetch_req=1, the FIFO is non-empty and pc_ld=0, the block SHALL pop the head.
- On the next cycle, ir_wr=1 and ir_data=head instr.
- pc_out <= head addr + 1.
REQ-018 When fetch_req=1 and the FIFO is empty, the block SHALL hold ir_wr=0.
- The request is not latched; the control unit re-asserts it.
REQ-019 ir_data SHALL hold its last value when ir_wr=0.
REQ-020 pc_ld SHALL take priority over fetch_req and over an im_valid arriving the same cycle.
- FIFO is flushed, fpc <= pc_in and pc_out <= pc_in.
- No ir_wr is produced in the following cycle.
REQ-021 pc_ld in DROP SHALL update fpc/pc_out and remain in DROP.
REQ-022 A same-cycle push and pop SHALL both take effect; overflow is impossible by REQ-015.
REQ-023 fpc and pc_out SHALL wrap 8'hFF -> 8'h00 with no flag.
REQ-024 halt=1 SHALL only block new issues: an outstanding read completes, and buffered entries still deliver.

Reset
REQ-025 On rst=1 at a clock edge, the block SHALL set:
- state=IDLE, FIFO empty, fpc=0, pc_out=0;
- im_rd=0, im_addr=0, ir_wr=0, ir_data=0.
REQ-026 Reset mid-read SHALL abandon the outstanding read.
- A stale im_valid in the first cycle after reset is ignored (post-reset state treats a response with no issued read as discarded).

Structure
REQ-027 Package fetch_pkg SHALL hold ADDR_W=8, INSTR_W=16, FIFO_DEPTH=2 and the FSM state enum.
REQ-028 The FIFO SHALL be the sub-module prefetch_fifo: 2-deep, push/pop/flush, count output.

Verification
REQ-029 Reset then 1-cycle memory latency, fetch_req held -> im_addr 00,01,02…; ir_wr pulses carry mem[00],mem[01]…; pc_out 01,02,03.
REQ-030 fetch_req=0 for 10 cycles -> exactly 2 reads issued (00,01); FIFO full; no further im_rd.
REQ-031 pc_ld with pc_in=8'h40 while a read of 02 is outstanding -> DROP; the 02 response is discarded; next im_addr=40; first ir_data=mem[40].
REQ-032 pc_ld=1 with fetch_req=1 and im_valid=1 in the same cycle -> no ir_wr next cycle; pc_out=pc_in; FIFO empty.
REQ-033 pc_ld to 8'hFE, fetch 4 instructions -> addresses FE,FF,00,01; pc_out wraps to 02.
REQ-034 halt=1 with 2 buffered entries, and separately rst during WAIT ->
- halt: 2 ir_wr pulses then none, im_rd=0;
- rst: all outputs 0 next cycle; a late im_valid produces no ir_wr.
